// File: rtl/inv_key_schedule_pkg.sv
// Shared definitions for the AES-128 key-step datapath and the
// decryption round-key scheduler: round count, FSM states, rcon and RotWord.
package inv_key_schedule_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // Round constant for expansion step idx; unused indices yield zero.
  function automatic logic [31:0] rcon(input logic [3:0] idx);
    logic [31:0] r;
    case (idx)
      4'd0:    r = 32'h0100_0000;
      4'd1:    r = 32'h0200_0000;
      4'd2:    r = 32'h0400_0000;
      4'd3:    r = 32'h0800_0000;
      4'd4:    r = 32'h1000_0000;
      4'd5:    r = 32'h2000_0000;
      4'd6:    r = 32'h4000_0000;
      4'd7:    r = 32'h8000_0000;
      4'd8:    r = 32'h1b00_0000;
      4'd9:    r = 32'h3600_0000;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // RotWord: byte2 moves to the top, byte3 wraps to the bottom.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/inv_key_schedule_step.sv
// One AES-128 key-expansion step, forward (dir=0) or inverse (dir=1).
// Both directions share a single 4-instance S-box bank; only its input
// differs: w3 going forward, w2^w3 (the recovered previous w3) going back.
module aes_key_step
  import inv_key_schedule_pkg::*;
(
  input  logic         dir,
  input  logic [127:0] key_in,
  input  logic [31:0]  rcon_word,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sb_in, sb_rot, sb_out, t;
  logic [31:0] f0, f1, f2, f3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  assign sb_in  = dir ? (w2 ^ w3) : w3;
  assign sb_rot = rot_word(sb_in);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      sbox u_sbox (
        .din  (sb_rot[8*gi +: 8]),
        .dout (sb_out[8*gi +: 8])
      );
    end
  endgenerate

  assign t = sb_out ^ rcon_word;

  // Forward chain: each word folds in the freshly updated word before it.
  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  // Select forward result or the inverse (undo the chain, then peel off t).
  always_comb begin
    key_out = {f0, f1, f2, f3};
    if (dir) begin
      key_out = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end
  end

endmodule

// File: rtl/sbox.sv
// AES forward S-box as a combinational lookup table.
module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX_TABLE[din];

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 decryption round-key generator: expands the cipher key forward
// to round 10, then streams round keys 10..0 over valid/ready, stepping
// backwards one round per accepted key.
module inv_key_schedule
  import inv_key_schedule_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         busy
);

  state_t       state_reg, state_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [3:0]   round_reg, round_next;
  logic         valid_reg, valid_next;
  logic [127:0] key_reg, key_next;

  logic [3:0]   rcon_idx;
  logic [127:0] step_out;
  logic         step_dir;

  // The inverse step for round r -> r-1 undoes forward step r-1.
  assign step_dir = (state_reg == EMIT);
  assign rcon_idx = step_dir ? (round_reg - 4'd1) : cnt_reg;

  aes_key_step u_step (
    .dir       (step_dir),
    .key_in    (key_reg),
    .rcon_word (rcon(rcon_idx)),
    .key_out   (step_out)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      round_reg <= 4'd0;
      valid_reg <= 1'b0;
      key_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      round_reg <= round_next;
      valid_reg <= valid_next;
      key_reg   <= key_next;
    end
  end

  // Next-state logic: load, expand 10 steps, then emit with backpressure.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    round_next = round_reg;
    valid_next = valid_reg;
    key_next   = key_reg;
    case (state_reg)
      IDLE: begin
        if (key_valid) begin
          key_next   = key;
          cnt_next   = 4'd0;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        key_next = step_out;
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'(NR - 1)) begin
          state_next = EMIT;
          valid_next = 1'b1;
          round_next = 4'(NR);
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_reg != 4'd0) begin
            key_next   = step_out;
            round_next = round_reg - 4'd1;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  assign key_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rk_valid  = valid_reg;
  assign rk        = key_reg;
  assign rk_round  = round_reg;
  assign rk_last   = valid_reg && (round_reg == 4'd0);

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: a forward FIPS-197 key expansion
// (with an arithmetic S-box) predicts each round key; the DUT stream is
// popped and compared on every rk handshake.
module tb_inv_key_schedule;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;

  inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk        (rk),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] key;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;
  int           accept_cyc = 0;
  int           last_done_cyc = 0;
  bit           wait_first = 0;
  bit           b2b_expect = 0;
  bit           prev_stall = 0;
  logic [127:0] snap_rk;
  logic [3:0]   snap_round;
  logic         snap_last;
  logic [127:0] kat [0:10];
  bit           kat_en [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_C    = 128'hdeadbeef0123456789abcdeffedcba98;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] sq = x;
    logic [7:0] inv = 8'h01;
    logic [7:0] b;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
  endfunction

  // Forward expansion; expected stream is rounds 10 down to 0.
  task automatic push_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    exp_t e;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 10; r >= 0; r--) begin
      e.round = 4'(r);
      e.key   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      sb.push_back(e);
    end
  endtask

  task automatic clear_kat();
    for (int r = 0; r <= 10; r++) kat_en[r] = 0;
  endtask

  task automatic set_kat(input int r, input logic [127:0] v);
    kat[r] = v;
    kat_en[r] = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, key_ready, 1'b1);
    check({tag, "_rk_valid"}, rk_valid, 1'b0);
    check({tag, "_rk"}, rk, 128'h0);
    check({tag, "_rk_round"}, rk_round, 4'd0);
    check({tag, "_rk_last"}, rk_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // One cycle: evaluate handshakes with the inputs now driven (we sit at a
  // negedge), then advance to the next negedge.
  task automatic step();
    exp_t e;
    if (prev_stall) begin
      check("stall_rk", rk, snap_rk);
      check("stall_round", rk_round, snap_round);
      check("stall_last", rk_last, snap_last);
      check("stall_valid", rk_valid, 1'b1);
    end
    prev_stall = 0;
    if (wait_first && rk_valid) begin
      check("first_valid_latency", cyc - accept_cyc, 11);
      wait_first = 0;
    end
    if (rk_valid && rk_ready) begin
      check("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("rk round %0d = %h (expected round %0d)", rk_round, rk, e.round);
        check("rk", rk, e.key);
        check("rk_round", rk_round, e.round);
        check("rk_last", rk_last, e.round == 4'd0);
        if (kat_en[e.round]) check("rk_kat", rk, kat[e.round]);
        if (e.round == 4'd0) last_done_cyc = cyc;
      end
    end else if (rk_valid) begin
      prev_stall = 1;
      snap_rk    = rk;
      snap_round = rk_round;
      snap_last  = rk_last;
    end
    if (key_valid && key_ready) begin
      $display("key accepted %h at cycle %0d", key, cyc);
      if (b2b_expect) begin
        check("b2b_gap", cyc - last_done_cyc, 1);
        b2b_expect = 0;
      end
      accept_cyc = cyc;
      wait_first = 1;
      push_key(key);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Run until only `left` expected keys remain; stall=1 randomises rk_ready.
  task automatic drain(input int left, input bit stall);
    int n = 0;
    while (sb.size() > left && n < 400) begin
      rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    check("drain_bound", sb.size(), left);
    rk_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key = '0;
    rk_ready = 1'b1;
    clear_kat();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 key, ready held high.
    set_kat(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    set_kat(9,  128'hac7766f319fadc2128d12941575c006e);
    set_kat(1,  128'ha0fafe1788542cb123a339392a6c7605);
    set_kat(0,  FIPS_KEY);
    key = FIPS_KEY;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("expand_busy", busy, 1'b1);
    check("expand_key_ready", key_ready, 1'b0);
    drain(0, 0);
    check("done_rk_valid", rk_valid, 1'b0);
    check("done_key_ready", key_ready, 1'b1);

    // Same key with random backpressure.
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    drain(0, 1);

    // All-zero key.
    clear_kat();
    set_kat(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    set_kat(0, 128'h0);
    key = '0;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    drain(0, 1);
    clear_kat();

    // key_valid held with a different key: ignored until round 0 done,
    // then accepted the very next cycle (back-to-back).
    key = KEY_C;
    key_valid = 1'b1;
    step();
    key = KEY_B;
    b2b_expect = 1;
    drain(0, 0);
    step();
    key_valid = 1'b0;
    check("b2b_accepted", b2b_expect, 1'b0);
    drain(0, 0);

    // Reset pulsed mid-EMIT after round 5 handshake.
    key = KEY_B;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    drain(5, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    prev_stall = 0;
    wait_first = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_kat(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    set_kat(0, FIPS_KEY);
    key = FIPS_KEY;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    drain(0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
